// File: rtl/fl_pkg.sv
// fl_pkg: shared constants and state encoding for the rename free list
package fl_pkg;
  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int PREG_W = 6;
  localparam int FIRST_FREE = 32;
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;
endpackage

// File: rtl/fl_mapped_decode.sv
// fl_mapped_decode: retirement RAT (r0 in the top bits) -> bitmap of mapped physical registers
module fl_mapped_decode #(
  parameter int PW = 6,
  parameter int DEPTH = 32
) (
  input  logic [DEPTH*PW-1:0]  retRat,
  output logic [(1<<PW)-1:0]   mapped
);
  always_comb begin
    mapped = '0;
    for (int r = 0; r < DEPTH; r++) mapped[retRat[(DEPTH-1-r)*PW +: PW]] = 1'b1;
  end
endmodule

// File: rtl/rename_free_list.sv
// rename_free_list: circular free list of physical IDs; one alloc/free per cycle, rebuilt from the retirement RAT on recovery
module rename_free_list
  import fl_pkg::*;
#(
  parameter int PHYS_ADDRWIDTH = 6,
  parameter int RETRAT_WIDTH = 6,
  parameter int RETRAT_DEPTH = 32
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  FREEZE,
  input  logic                                  tFL_freeReq_IN,
  input  logic [PHYS_ADDRWIDTH-1:0]             tFL_freeId_IN,
  input  logic                                  tFL_allocReq_IN,
  output logic [PHYS_ADDRWIDTH-1:0]             fFL_allocId_OUT,
  output logic                                  fFL_allocValid_OUT,
  output logic [PHYS_ADDRWIDTH:0]               fFL_count_OUT,
  input  logic                                  tFL_recover_IN,
  input  logic [RETRAT_DEPTH*RETRAT_WIDTH-1:0]  tFL_retRat_IN,
  output logic                                  fFL_busy_OUT,
  output logic                                  fFL_overflow_OUT
);
  localparam int NP = 1 << PHYS_ADDRWIDTH;
  localparam int CW = PHYS_ADDRWIDTH + 1;
  logic [PHYS_ADDRWIDTH-1:0] mem [NP];
  logic [PHYS_ADDRWIDTH-1:0] head, tail, idx;
  logic [CW-1:0] count;
  logic [NP-1:0] mapped, snap;
  logic recPend, ovf, full, doFree, doAlloc;
  state_t state;
  fl_mapped_decode #(.PW(RETRAT_WIDTH), .DEPTH(RETRAT_DEPTH)) u_decode (
    .retRat(tFL_retRat_IN),
    .mapped(mapped)
  );
  assign full = count == CW'(NP);
  assign fFL_allocId_OUT = mem[head];
  assign fFL_allocValid_OUT = count != '0 && state == IDLE && !recPend;
  assign fFL_count_OUT = count;
  assign fFL_busy_OUT = state == SCAN || recPend;
  assign fFL_overflow_OUT = ovf;
  assign doFree = tFL_freeReq_IN && !full;
  assign doAlloc = tFL_allocReq_IN && fFL_allocValid_OUT;
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < NP - FIRST_FREE; i++) mem[i] <= PHYS_ADDRWIDTH'(FIRST_FREE + i);
      head <= '0;
      tail <= PHYS_ADDRWIDTH'(FIRST_FREE);
      count <= CW'(FIRST_FREE);
      idx <= '0;
      snap <= '0;
      state <= IDLE;
      recPend <= 1'b0;
      ovf <= 1'b0;
    end else if (FREEZE) begin
      if (tFL_recover_IN) recPend <= 1'b1;
    end else if (tFL_recover_IN || recPend) begin
      snap <= mapped;
      head <= '0;
      tail <= '0;
      count <= '0;
      idx <= '0;
      state <= SCAN;
      recPend <= 1'b0;
    end else if (state == SCAN) begin
      if (!snap[idx]) begin
        mem[tail] <= idx;
        tail <= tail + 1'b1;
        count <= count + 1'b1;
      end
      idx <= idx + 1'b1;
      if (idx == PHYS_ADDRWIDTH'(NP - 1)) state <= IDLE;
    end else begin
      if (doFree) begin
        mem[tail] <= tFL_freeId_IN;
        tail <= tail + 1'b1;
      end
      if (tFL_freeReq_IN && full) ovf <= 1'b1;
      if (doAlloc) head <= head + 1'b1;
      count <= count + CW'(doFree) - CW'(doAlloc);
    end
  end
endmodule

// File: tb/tb_rename_free_list.sv
// tb_rename_free_list: vector table, corner sequences and random traffic against a queue-based reference model
module tb_rename_free_list;
  logic CLK = 1'b0, RESET = 1'b0, FREEZE = 1'b0;
  logic freeReq = 1'b0, allocReq = 1'b0, recover = 1'b0;
  logic [5:0] freeId = '0, allocId;
  logic allocValid, busy, overflow;
  logic [6:0] count;
  logic [191:0] retRat;
  int rat [32];
  int tests = 0, fails = 0;
  int q[$];
  bit mOvf, mPend, mScan;
  int mIdx;
  bit mSnap [64];
  always #5 CLK = ~CLK;
  rename_free_list dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
    .tFL_freeReq_IN(freeReq), .tFL_freeId_IN(freeId), .tFL_allocReq_IN(allocReq),
    .fFL_allocId_OUT(allocId), .fFL_allocValid_OUT(allocValid), .fFL_count_OUT(count),
    .tFL_recover_IN(recover), .tFL_retRat_IN(retRat),
    .fFL_busy_OUT(busy), .fFL_overflow_OUT(overflow)
  );
  always_comb begin
    retRat = '0;
    for (int r = 0; r < 32; r++) retRat[(31-r)*6 +: 6] = 6'(rat[r]);
  end
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_edge();
    if (!RESET) begin
      q.delete();
      for (int i = 32; i < 64; i++) q.push_back(i);
      mOvf = 0; mPend = 0; mScan = 0;
    end else if (FREEZE) begin
      if (recover) mPend = 1;
    end else if (recover || mPend) begin
      foreach (mSnap[p]) mSnap[p] = 0;
      foreach (rat[r]) mSnap[rat[r]] = 1;
      q.delete(); mScan = 1; mIdx = 0; mPend = 0;
    end else if (mScan) begin
      if (!mSnap[mIdx]) q.push_back(mIdx);
      mIdx++;
      if (mIdx == 64) mScan = 0;
    end else begin
      automatic bit wasFull = q.size() == 64;
      if (allocReq && q.size() > 0) void'(q.pop_front());
      if (freeReq) begin
        if (wasFull) mOvf = 1;
        else q.push_back(int'(freeId));
      end
    end
  endfunction
  task automatic check_model();
    automatic bit v = q.size() > 0 && !mScan && !mPend;
    chk("count", int'(count), q.size());
    chk("allocValid", int'(allocValid), int'(v));
    chk("busy", int'(busy), int'(mScan || mPend));
    chk("overflow", int'(overflow), int'(mOvf));
    if (v) chk("allocId", int'(allocId), q[0]);
  endtask
  task automatic step(input bit fr, input int fid, input bit al, input bit rc, input bit fz, input bit rs);
    freeReq = fr; freeId = 6'(fid); allocReq = al; recover = rc; FREEZE = fz; RESET = rs;
    @(posedge CLK);
    model_edge();
    #1;
    check_model();
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 1);
  endtask
  task automatic do_reset();
    foreach (rat[r]) rat[r] = r;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic wait_scan(input string name, input int expCycles);
    int n = 0;
    bit sawValid = 0;
    while (busy && n < 200) begin
      if (allocValid) sawValid = 1;
      idle();
      n++;
    end
    chk({name, "_busyCycles"}, n, expCycles);
    chk({name, "_validDuringScan"}, int'(sawValid), 0);
  endtask
  typedef struct {
    bit fr; int fid; bit al; bit rs;
    int expCount; int expId; bit expValid;
  } vec_t;
  vec_t vecs [8];
  initial begin
    vecs[0] = '{0, 0, 0, 0, 32, 32, 1};
    vecs[1] = '{0, 0, 1, 1, 31, 33, 1};
    vecs[2] = '{0, 0, 1, 1, 30, 34, 1};
    vecs[3] = '{0, 0, 1, 1, 29, 35, 1};
    vecs[4] = '{1, 7, 1, 1, 29, 36, 1};
    vecs[5] = '{1, 9, 0, 1, 30, 36, 1};
    vecs[6] = '{0, 0, 1, 1, 29, 37, 1};
    vecs[7] = '{0, 0, 0, 0, 32, 32, 1};
    foreach (rat[r]) rat[r] = r;
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].fr, vecs[i].fid, vecs[i].al, 0, 0, vecs[i].rs);
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].expCount);
      chk($sformatf("vec%0d_allocId", i), int'(allocId), vecs[i].expId);
      chk($sformatf("vec%0d_valid", i), int'(allocValid), int'(vecs[i].expValid));
    end
    do_reset();
    step(1, 7, 1, 0, 0, 1);
    chk("sameCycle_count", int'(count), 32);
    for (int i = 0; i < 31; i++) step(0, 0, 1, 0, 0, 1);
    chk("freedReachesHead", int'(allocId), 7);
    do_reset();
    for (int i = 0; i < 32; i++) step(1, i, 0, 0, 0, 1);
    chk("full_count", int'(count), 64);
    chk("full_noOverflowYet", int'(overflow), 0);
    step(1, 50, 0, 0, 0, 1);
    chk("overflow_set", int'(overflow), 1);
    chk("overflow_count", int'(count), 64);
    do_reset();
    rat[5] = 40;
    step(0, 0, 0, 1, 0, 1);
    chk("trigger_busy", int'(busy), 1);
    chk("trigger_count", int'(count), 0);
    wait_scan("rebuild", 64);
    chk("rebuild_count", int'(count), 32);
    begin
      int exp [10] = '{5, 32, 33, 34, 35, 36, 37, 38, 39, 41};
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("rebuild_alloc%0d", i), int'(allocId), exp[i]);
        step(0, 0, 1, 0, 0, 1);
      end
    end
    do_reset();
    step(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      chk("frozen_count", int'(count), 32);
      chk("frozen_valid", int'(allocValid), 0);
      chk("frozen_busy", int'(busy), 1);
      step(0, 0, 1, 0, 1, 1);
    end
    step(1, 3, 1, 0, 0, 1);
    chk("pendingTrigger_count", int'(count), 0);
    wait_scan("pendingRebuild", 64);
    chk("pendingRebuild_count", int'(count), 32);
    chk("pendingRebuild_head", int'(allocId), 32);
    step(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 20; i++) idle();
    step(0, 0, 0, 0, 0, 0);
    chk("midScanReset_count", int'(count), 32);
    chk("midScanReset_id", int'(allocId), 32);
    chk("midScanReset_busy", int'(busy), 0);
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 39) == 0) rat[$urandom_range(0, 31)] = $urandom_range(0, 63);
      step($urandom_range(0, 99) < 45, $urandom_range(0, 63), $urandom_range(0, 99) < 50,
           $urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1999) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
